// File: rtl/collision_pkg.sv
// Shared field layout, widths and FSM states for the platform/fence collision scanner.
// Table records are packed by the world map stage; the slice positions below mirror that packing.
package collision_pkg;

   localparam int REC_W = 29;  // bits per packed table record
   localparam int SUM_W = 11;  // one bit wider than any coordinate, so sums never wrap
   localparam int IDX_W = 4;   // entry index width, tables hold up to 16 entries

   // Ground record: x_start, y, length
   localparam int GX_LO = 0;
   localparam int GX_HI = 9;
   localparam int GY_LO = 10;
   localparam int GY_HI = 18;
   localparam int GL_LO = 19;
   localparam int GL_HI = 28;

   // Fence record: y_start, x, length
   localparam int FY_LO = 0;
   localparam int FY_HI = 8;
   localparam int FX_LO = 9;
   localparam int FX_HI = 18;
   localparam int FL_LO = 19;
   localparam int FL_HI = 28;

   localparam int DEF_N_GROUND = 16;
   localparam int DEF_N_FENCE  = 16;
   localparam int DEF_PLAYER_W = 16;
   localparam int DEF_PLAYER_H = 16;
   localparam int DEF_SNAP     = 4;
   localparam int DEF_REACH    = 2;

   typedef enum logic [1:0] {
      IDLE,
      SCAN_G,
      SCAN_F,
      DONE
   } state_t;

endpackage

// File: rtl/platform_collision_scanner_if.sv
// Frame request, live terrain tables and contact results between world map, scanner and player motion.
interface platform_collision_scanner_if
   import collision_pkg::*;
#(
   parameter int N_GROUND = DEF_N_GROUND,
   parameter int N_FENCE  = DEF_N_FENCE
);

   logic                             start;
   logic [9:0]                       player_x;
   logic [9:0]                       player_y;
   logic [N_GROUND-1:0][REC_W-1:0]   info_ground;
   logic [N_FENCE-1:0][REC_W-1:0]    info_fence;
   logic                             busy;
   logic                             done;
   logic                             on_ground;
   logic [8:0]                       ground_y;
   logic [IDX_W-1:0]                 ground_idx;
   logic                             blocked_left;
   logic                             blocked_right;

   modport master (
      output start, player_x, player_y, info_ground, info_fence,
      input  busy, done, on_ground, ground_y, ground_idx, blocked_left, blocked_right
   );

   modport slave (
      input  start, player_x, player_y, info_ground, info_fence,
      output busy, done, on_ground, ground_y, ground_idx, blocked_left, blocked_right
   );

endinterface

// File: rtl/span_overlap.sv
// Combinational 1-D interval test: [a_lo, a_lo+a_len) intersects [b_lo, b_lo+b_len).
// Comparisons only add, so an interval starting at 0 never underflows.
module span_overlap
   import collision_pkg::*;
(
   input  logic [SUM_W-1:0] a_lo,
   input  logic [SUM_W-1:0] a_len,
   input  logic [SUM_W-1:0] b_lo,
   input  logic [SUM_W-1:0] b_len,
   output logic             overlap
);

   assign overlap = ((a_lo + a_len) > b_lo) && (a_lo < (b_lo + b_len));

endmodule

// File: rtl/platform_collision_scanner.sv
// Once-per-frame player-vs-terrain contact resolver: walks ground entries, then fence entries,
// one per cycle, and publishes on_ground / landing height / side block flags on a done pulse.
module platform_collision_scanner
   import collision_pkg::*;
#(
   parameter int N_GROUND = DEF_N_GROUND,
   parameter int N_FENCE  = DEF_N_FENCE,
   parameter int PLAYER_W = DEF_PLAYER_W,
   parameter int PLAYER_H = DEF_PLAYER_H,
   parameter int SNAP     = DEF_SNAP,
   parameter int REACH    = DEF_REACH
)(
   input  logic                         Clk,
   input  logic                         Reset_n,
   platform_collision_scanner_if.slave  bus
);

   state_t            state, state_nxt;
   logic [9:0]        px, py;
   logic [IDX_W-1:0]  idx;
   logic              idx_last;

   logic              acc_hit, acc_left, acc_right;
   logic [8:0]        acc_y;
   logic [IDX_W-1:0]  acc_idx;

   logic              on_ground_q, left_q, right_q, done_q;
   logic [8:0]        ground_y_q;
   logic [IDX_W-1:0]  ground_idx_q;

   // Current entry fields; tables are read live so moving platforms are seen where they are now
   logic [REC_W-1:0]       g_rec, f_rec;
   logic [GX_HI-GX_LO:0]   g_x;
   logic [GY_HI-GY_LO:0]   g_y;
   logic [GL_HI-GL_LO:0]   g_len;
   logic [FY_HI-FY_LO:0]   f_y;
   logic [FX_HI-FX_LO:0]   f_x;
   logic [FL_HI-FL_LO:0]   f_len;

   assign g_rec = bus.info_ground[idx];
   assign f_rec = bus.info_fence[idx];
   assign g_x   = g_rec[GX_HI:GX_LO];
   assign g_y   = g_rec[GY_HI:GY_LO];
   assign g_len = g_rec[GL_HI:GL_LO];
   assign f_y   = f_rec[FY_HI:FY_LO];
   assign f_x   = f_rec[FX_HI:FX_LO];
   assign f_len = f_rec[FL_HI:FL_LO];

   logic [SUM_W-1:0] px_w, py_w, bottom, right_edge, gy_w, fx_w;
   logic             g_x_ok, g_y_ok, g_hit, f_y_ok, f_left, f_right;

   assign px_w       = SUM_W'(px);
   assign py_w       = SUM_W'(py);
   assign bottom     = py_w + SUM_W'(PLAYER_H);
   assign right_edge = px_w + SUM_W'(PLAYER_W);
   assign gy_w       = SUM_W'(g_y);
   assign fx_w       = SUM_W'(f_x);

   span_overlap u_ground_x (
      .a_lo    (px_w),
      .a_len   (SUM_W'(PLAYER_W)),
      .b_lo    (SUM_W'(g_x)),
      .b_len   (SUM_W'(g_len)),
      .overlap (g_x_ok)
   );

   span_overlap u_fence_y (
      .a_lo    (py_w),
      .a_len   (SUM_W'(PLAYER_H)),
      .b_lo    (SUM_W'(f_y)),
      .b_len   (SUM_W'(f_len)),
      .overlap (f_y_ok)
   );

   // Zero-length entries are empty slots and must never register a contact
   assign g_y_ok  = (gy_w <= bottom) && (bottom < (gy_w + SUM_W'(SNAP)));
   assign g_hit   = (g_len != '0) && g_x_ok && g_y_ok;
   assign f_left  = (f_len != '0) && f_y_ok && (fx_w <= px_w) && ((fx_w + SUM_W'(REACH)) >= px_w);
   assign f_right = (f_len != '0) && f_y_ok && (fx_w >= right_edge)
                    && (fx_w <= (right_edge + SUM_W'(REACH)));

   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no latch is inferred.
      state_nxt = state;
      idx_last  = 1'b0;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN_G;
         SCAN_G: begin
            idx_last = (idx == IDX_W'(N_GROUND - 1));
            if (idx_last) state_nxt = SCAN_F;
         end
         SCAN_F: begin
            idx_last = (idx == IDX_W'(N_FENCE - 1));
            if (idx_last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         px           <= '0;
         py           <= '0;
         idx          <= '0;
         acc_hit      <= 1'b0;
         acc_y        <= '0;
         acc_idx      <= '0;
         acc_left     <= 1'b0;
         acc_right    <= 1'b0;
         done_q       <= 1'b0;
         on_ground_q  <= 1'b0;
         ground_y_q   <= '0;
         ground_idx_q <= '0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  px        <= bus.player_x;
                  py        <= bus.player_y;
                  idx       <= '0;
                  acc_hit   <= 1'b0;
                  acc_y     <= '0;
                  acc_idx   <= '0;
                  acc_left  <= 1'b0;
                  acc_right <= 1'b0;
               end
            end
            SCAN_G: begin
               // Strict less-than keeps the lower index on an equal-height tie
               if (g_hit && (!acc_hit || (g_y < acc_y))) begin
                  acc_hit <= 1'b1;
                  acc_y   <= g_y;
                  acc_idx <= idx;
               end
               idx <= idx_last ? '0 : idx + 1'b1;
            end
            SCAN_F: begin
               acc_left  <= acc_left  | f_left;
               acc_right <= acc_right | f_right;
               idx       <= idx_last ? '0 : idx + 1'b1;
            end
            DONE: begin
               done_q       <= 1'b1;
               on_ground_q  <= acc_hit;
               ground_y_q   <= acc_y;
               ground_idx_q <= acc_idx;
               left_q       <= acc_left;
               right_q      <= acc_right;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy          = (state == SCAN_G) || (state == SCAN_F);
   assign bus.done          = done_q;
   assign bus.on_ground     = on_ground_q;
   assign bus.ground_y      = ground_y_q;
   assign bus.ground_idx    = ground_idx_q;
   assign bus.blocked_left  = left_q;
   assign bus.blocked_right = right_q;

endmodule

// File: tb/tb_platform_collision_scanner.sv
// Directed bench for platform_collision_scanner: a contact model computed from the geometric rules,
// a per-cycle compare of busy/done/results, and literal expectations for each scenario.
module tb_platform_collision_scanner;

   localparam int PW      = 16;
   localparam int PH      = 16;
   localparam int SNAPV   = 4;
   localparam int REACHV  = 2;
   localparam int LATENCY = 33;

   typedef struct {
      int on;
      int gy;
      int gidx;
      int left;
      int right;
   } res_t;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   platform_collision_scanner_if #(.N_GROUND(16), .N_FENCE(16)) bus ();

   platform_collision_scanner dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   logic [15:0][28:0] g_tab;
   logic [15:0][28:0] f_tab;
   assign bus.info_ground = g_tab;
   assign bus.info_fence  = f_tab;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   start_cyc = -1000;
   res_t pending, shown;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic [28:0] mk_g(input int x, input int y, input int len);
      return {10'(len), 9'(y), 10'(x)};
   endfunction

   function automatic logic [28:0] mk_f(input int ys, input int x, input int len);
      return {10'(len), 10'(x), 9'(ys)};
   endfunction

   // Contact rules evaluated directly over the whole table in integer arithmetic
   function automatic res_t model(input int px, input int py);
      res_t r;
      int   x, y, l, bot;
      r = '{on: 0, gy: 0, gidx: 0, left: 0, right: 0};
      bot = py + PH;
      for (int i = 0; i < 16; i++) begin
         x = int'(g_tab[i][9:0]);
         y = int'(g_tab[i][18:10]);
         l = int'(g_tab[i][28:19]);
         if (l > 0 && px + PW > x && px < x + l && bot >= y && bot < y + SNAPV) begin
            if (r.on == 0 || y < r.gy) begin
               r.on = 1; r.gy = y; r.gidx = i;
            end
         end
      end
      for (int i = 0; i < 16; i++) begin
         y = int'(f_tab[i][8:0]);
         x = int'(f_tab[i][18:9]);
         l = int'(f_tab[i][28:19]);
         if (l > 0 && py < y + l && py + PH > y) begin
            if (x <= px && x + REACHV >= px) r.left = 1;
            if (x >= px + PW && x <= px + PW + REACHV) r.right = 1;
         end
      end
      return r;
   endfunction

   // Per-cycle compare: handshake timing and held results against the model
   always @(posedge Clk) begin
      #1;
      if (cyc == start_cyc + LATENCY) shown = pending;
      check("busy", int'(bus.busy), int'(cyc >= start_cyc && cyc <= start_cyc + LATENCY - 2));
      check("done", int'(bus.done), int'(cyc == start_cyc + LATENCY));
      check("on_ground", int'(bus.on_ground), shown.on);
      check("ground_y", int'(bus.ground_y), shown.gy);
      check("ground_idx", int'(bus.ground_idx), shown.gidx);
      check("blocked_left", int'(bus.blocked_left), shown.left);
      check("blocked_right", int'(bus.blocked_right), shown.right);
   end

   task automatic run_scan(input int px, input int py);
      @(negedge Clk);
      bus.player_x = 10'(px);
      bus.player_y = 10'(py);
      pending      = model(px, py);
      start_cyc    = cyc + 1;
      bus.start    = 1'b1;
      @(negedge Clk);
      bus.start    = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < LATENCY + 8 && !seen; i++) begin
         @(posedge Clk);
         #1;
         seen = bus.done;
      end
      check("done_seen", int'(seen), 1);
      if (seen) check("latency", cyc - start_cyc, LATENCY);
   endtask

   task automatic expect_res(input string tag, input int on, input int gy, input int gi,
                             input int l, input int r);
      check({tag, "_on"}, int'(bus.on_ground), on);
      check({tag, "_gy"}, int'(bus.ground_y), gy);
      check({tag, "_gidx"}, int'(bus.ground_idx), gi);
      check({tag, "_left"}, int'(bus.blocked_left), l);
      check({tag, "_right"}, int'(bus.blocked_right), r);
   endtask

   initial begin
      Reset_n      = 1'b0;
      bus.start    = 1'b0;
      bus.player_x = '0;
      bus.player_y = '0;
      g_tab        = '0;
      f_tab        = '0;
      pending      = '{on: 0, gy: 0, gidx: 0, left: 0, right: 0};
      shown        = pending;

      repeat (3) @(negedge Clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      expect_res("rst", 0, 0, 0, 0, 0);
      Reset_n = 1'b1;

      // Single platform, bottom exactly on y, then inside and just past the snap window
      g_tab[1] = mk_g(100, 380, 120);
      run_scan(110, 364); wait_done(); expect_res("land", 1, 380, 1, 0, 0);
      run_scan(110, 366); wait_done(); expect_res("snap_in", 1, 380, 1, 0, 0);
      run_scan(110, 369); wait_done(); expect_res("snap_out", 0, 0, 0, 0, 0);

      // Two hits: higher platform wins; equal heights go to the lower index
      g_tab    = '0;
      g_tab[0] = mk_g(0, 430, 639);
      g_tab[3] = mk_g(100, 428, 60);
      run_scan(110, 414); wait_done(); expect_res("two_hit", 1, 428, 3, 0, 0);
      g_tab[3] = mk_g(100, 430, 60);
      run_scan(110, 414); wait_done(); expect_res("tie", 1, 430, 0, 0, 0);

      // Fence on either side, then out of vertical range
      g_tab    = '0;
      f_tab[0] = mk_f(382, 102, 48);
      run_scan(104, 400); wait_done(); expect_res("fence_l", 0, 0, 0, 1, 0);
      run_scan(84, 400);  wait_done(); expect_res("fence_r", 0, 0, 0, 0, 1);
      run_scan(104, 300); wait_done(); expect_res("fence_none", 0, 0, 0, 0, 0);

      // Second start mid-scan is ignored: one done, nothing queued afterwards
      g_tab[5] = mk_g(100, 380, 120);
      run_scan(110, 364);
      repeat (9) @(negedge Clk);
      bus.start = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      wait_done(); expect_res("restart", 1, 380, 5, 0, 0);
      repeat (LATENCY + 5) @(negedge Clk);

      // Reset mid-scan aborts: outputs clear and no done pulse follows
      run_scan(104, 300);
      repeat (19) @(negedge Clk);
      Reset_n   = 1'b0;
      start_cyc = -1000;
      shown     = '{on: 0, gy: 0, gidx: 0, left: 0, right: 0};
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (LATENCY + 5) @(negedge Clk);
      expect_res("abort", 0, 0, 0, 0, 0);

      // Left edge at x=0 against a fence at x=0; zero-length entries that would otherwise hit
      g_tab    = '0;
      f_tab    = '0;
      f_tab[0] = mk_f(0, 0, 479);
      g_tab[2] = mk_g(10, 116, 0);
      f_tab[1] = mk_f(105, 21, 0);
      run_scan(0, 100); wait_done(); expect_res("x0_fence", 0, 0, 0, 1, 0);
      run_scan(5, 100); wait_done(); expect_res("zero_len", 0, 0, 0, 0, 0);

      repeat (3) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
